// File: rtl/acc_demo_flag_rx_decode_if.sv
// ----------------------------------------------------------------------------
// acc_demo_flag_rx_decode_if
//  Word strobe bus between serial_rx and the acc-demo / PMT-scan decoder.
//  Ports / signals:
//   rx_valid  single-cycle strobe: rx_data holds a complete word
//   rx_data   received word, DATA_WIDTH bits
//  Modports:
//   master    serial_rx side, drives the word
//   slave     decoder side, samples the word
// ----------------------------------------------------------------------------
interface acc_demo_flag_rx_decode_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   logic                  rx_valid;
   logic [DATA_WIDTH-1:0] rx_data;

   modport master (output rx_valid, output rx_data);
   modport slave  (input  rx_valid, input  rx_data);
endinterface

// File: rtl/acc_demo_flag_rx_decode.sv
// ----------------------------------------------------------------------------
// acc_demo_flag_rx_decode
//  Receive-side decoder for the acc-demo / PMT-scan sync link. Consumes the
//  16-bit sync words from serial_rx, rebuilds the acc_demo level, tracks the
//  scan state (IDLE / SCAN / SCAN_TEST), emits scan begin/end pulses and
//  keeps saturating counters of unknown and out-of-sequence words.
//  Ports:
//   clk_i               in   system clock
//   rst_n_i             in   synchronous reset, active-low
//   rx_if               in   word strobe bus (rx_valid / rx_data), slave side
//   err_clr_i           in   synchronous clear of both error counters
//   acc_demo_flag_o     out  rebuilt acc_demo level
//   pmt_start_en_o      out  high while in SCAN or SCAN_TEST
//   pmt_start_test_en_o out  high only in SCAN_TEST
//   scan_begin_o        out  1-clk pulse on entry to SCAN or SCAN_TEST
//   scan_end_o          out  1-clk pulse on return to IDLE
//   unknown_cnt_o       out  count of words matching no sync constant
//   seq_err_cnt_o       out  count of legal words received in an illegal state
// ----------------------------------------------------------------------------
module acc_demo_flag_rx_decode #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ERR_CNT_W  = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   acc_demo_flag_rx_decode_if.slave   rx_if,
   input  logic                       err_clr_i,
   output logic                       acc_demo_flag_o,
   output logic                       pmt_start_en_o,
   output logic                       pmt_start_test_en_o,
   output logic                       scan_begin_o,
   output logic                       scan_end_o,
   output logic [ERR_CNT_W-1:0]       unknown_cnt_o,
   output logic [ERR_CNT_W-1:0]       seq_err_cnt_o
);

   // Sync constants, zero-extended to the word width.
   localparam logic [DATA_WIDTH-1:0] SYNC_ACC1 = DATA_WIDTH'(16'hACC1);
   localparam logic [DATA_WIDTH-1:0] SYNC_ACC0 = DATA_WIDTH'(16'hACC0);
   localparam logic [DATA_WIDTH-1:0] SYNC_SCAN = DATA_WIDTH'(16'h5A51);
   localparam logic [DATA_WIDTH-1:0] SYNC_TEST = DATA_WIDTH'(16'h5A53);
   localparam logic [DATA_WIDTH-1:0] SYNC_END  = DATA_WIDTH'(16'h5A50);

   // Encoding chosen so each enable is a single state flop:
   // bit0 = scanning, bit1 = test scan.
   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      SCAN      = 2'b01,
      SCAN_TEST = 2'b11
   } state_e;

   typedef enum logic [2:0] {
      W_NONE,
      W_ACC1,
      W_ACC0,
      W_SCAN,
      W_TEST,
      W_END,
      W_UNK
   } word_e;

   state_e                 state_q, state_d;
   word_e                  word;
   logic                   acc_q, acc_d;
   logic                   scan_begin_q, scan_begin_d;
   logic                   scan_end_q, scan_end_d;
   logic                   seq_ev, unk_ev;
   logic [ERR_CNT_W-1:0]   unk_cnt_q, unk_cnt_d;
   logic [ERR_CNT_W-1:0]   seq_cnt_q, seq_cnt_d;

   // Classify the incoming word; nothing is seen without the strobe.
   always_comb begin
      word = W_NONE;
      if (rx_if.rx_valid) begin
         unique case (rx_if.rx_data)
            SYNC_ACC1: word = W_ACC1;
            SYNC_ACC0: word = W_ACC0;
            SYNC_SCAN: word = W_SCAN;
            SYNC_TEST: word = W_TEST;
            SYNC_END:  word = W_END;
            default:   word = W_UNK;
         endcase
      end
   end

   // Next-state, pulses and error events.
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      scan_begin_d = 1'b0;
      scan_end_d   = 1'b0;
      seq_ev       = 1'b0;
      unk_ev       = 1'b0;

      unique case (word)
         W_ACC1: begin
            if (acc_q) seq_ev = 1'b1;   // repeated edge: a falling edge was lost
            else       acc_d  = 1'b1;
         end
         W_ACC0: begin
            if (!acc_q) seq_ev = 1'b1;
            else        acc_d  = 1'b0;
         end
         W_SCAN, W_TEST: begin
            if (state_q == IDLE) begin
               state_d      = (word == W_TEST) ? SCAN_TEST : SCAN;
               scan_begin_d = 1'b1;
            end else begin
               seq_ev = 1'b1;           // no mode switch mid-scan
            end
         end
         W_END: begin
            if (state_q != IDLE) begin
               state_d    = IDLE;
               scan_end_d = 1'b1;
            end else begin
               seq_ev = 1'b1;
            end
         end
         W_UNK:   unk_ev = 1'b1;
         default: ;
      endcase
   end

   // Saturating counters; a clear swallows any same-cycle event.
   always_comb begin
      unk_cnt_d = unk_cnt_q;
      seq_cnt_d = seq_cnt_q;
      if (err_clr_i) begin
         unk_cnt_d = '0;
         seq_cnt_d = '0;
      end else begin
         if (unk_ev && (unk_cnt_q != '1)) unk_cnt_d = unk_cnt_q + ERR_CNT_W'(1);
         if (seq_ev && (seq_cnt_q != '1)) seq_cnt_d = seq_cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         acc_q        <= 1'b0;
         scan_begin_q <= 1'b0;
         scan_end_q   <= 1'b0;
         unk_cnt_q    <= '0;
         seq_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         scan_begin_q <= scan_begin_d;
         scan_end_q   <= scan_end_d;
         unk_cnt_q    <= unk_cnt_d;
         seq_cnt_q    <= seq_cnt_d;
      end
   end

   assign acc_demo_flag_o     = acc_q;
   assign pmt_start_en_o      = state_q[0];
   assign pmt_start_test_en_o = state_q[1];
   assign scan_begin_o        = scan_begin_q;
   assign scan_end_o          = scan_end_q;
   assign unknown_cnt_o       = unk_cnt_q;
   assign seq_err_cnt_o       = seq_cnt_q;

endmodule
